// File: rtl/dram_client_arbiter.sv
// Two-client arbiter onto a tagged DRAM request/response channel. Allocates
// transaction IDs, remembers which client owns each ID and routes responses home.
module dram_client_arbiter #(
  parameter int NUM_IDS = 8,
  parameter bit RR      = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         c0_req_valid,
  output logic         c0_req_ready,
  input  logic [31:0]  c0_req_bits_addr,
  input  logic [127:0] c0_req_bits_data,
  input  logic         c0_req_bits_isWr,
  input  logic [15:0]  c0_req_bits_mask,
  output logic         c0_resp_valid,
  input  logic         c0_resp_ready,
  output logic [127:0] c0_resp_bits_data,
  input  logic         c1_req_valid,
  output logic         c1_req_ready,
  input  logic [31:0]  c1_req_bits_addr,
  input  logic [127:0] c1_req_bits_data,
  input  logic         c1_req_bits_isWr,
  input  logic [15:0]  c1_req_bits_mask,
  output logic         c1_resp_valid,
  input  logic         c1_resp_ready,
  output logic [127:0] c1_resp_bits_data,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic [3:0]   mem_req_bits_id,
  output logic [31:0]  mem_req_bits_addr,
  output logic [127:0] mem_req_bits_data,
  output logic         mem_req_bits_isWr,
  output logic [15:0]  mem_req_bits_mask,
  input  logic         mem_resp_valid,
  output logic         mem_resp_ready,
  input  logic [3:0]   mem_resp_bits_id,
  input  logic [127:0] mem_resp_bits_data,
  output logic [4:0]   outstanding,
  output logic         err_unexpected_id
);

  // All channels: a transfer happens on a rising edge where valid && ready;
  // a producer holding valid keeps its payload stable until that edge.

  localparam logic [15:0] ID_MASK = (NUM_IDS >= 16) ? 16'hFFFF
                                  : 16'((32'd1 << NUM_IDS) - 32'd1);

  logic         slot_valid_q, slot_valid_d;
  logic [3:0]   slot_id_q,    slot_id_d;
  logic [31:0]  slot_addr_q,  slot_addr_d;
  logic [127:0] slot_data_q,  slot_data_d;
  logic         slot_wr_q,    slot_wr_d;
  logic [15:0]  slot_mask_q,  slot_mask_d;
  logic [15:0]  busy_q,       busy_d;
  logic [15:0]  owner_q,      owner_d;
  logic         pref_q,       pref_d;
  logic [4:0]   count_q,      count_d;
  logic         err_q,        err_d;

  logic [15:0]  free_vec;
  logic         free_any;
  logic [3:0]   alloc_id;
  logic         slot_open;
  logic         grant_ok;
  logic         win;
  logic         accept;
  logic [31:0]  sel_addr;
  logic         resp_known;
  logic         resp_owner;
  logic         resp_free;

  // Grant: lowest free ID, slot open, winner picked from valids and RR pointer.
  always_comb begin
    free_vec = ~busy_q & ID_MASK;
    free_any = |free_vec;
    alloc_id = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (free_vec[i]) alloc_id = 4'(i);
    end
    slot_open = !slot_valid_q || mem_req_ready;
    grant_ok  = reset && slot_open && free_any;
    if (c0_req_valid && c1_req_valid) win = RR ? pref_q : 1'b1;
    else                              win = c1_req_valid;
    c0_req_ready = grant_ok && !win;
    c1_req_ready = grant_ok && win;
    accept       = grant_ok && (win ? c1_req_valid : c0_req_valid);
    sel_addr     = win ? c1_req_bits_addr : c0_req_bits_addr;
  end

  // Response routing is purely combinational on the owner table.
  always_comb begin
    resp_known        = busy_q[mem_resp_bits_id];
    resp_owner        = owner_q[mem_resp_bits_id];
    mem_resp_ready    = resp_known ? (resp_owner ? c1_resp_ready : c0_resp_ready) : 1'b1;
    c0_resp_valid     = mem_resp_valid && resp_known && !resp_owner;
    c1_resp_valid     = mem_resp_valid && resp_known && resp_owner;
    c0_resp_bits_data = mem_resp_bits_data;
    c1_resp_bits_data = mem_resp_bits_data;
    resp_free         = mem_resp_valid && mem_resp_ready && resp_known;
  end

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_id_d    = slot_id_q;
    slot_addr_d  = slot_addr_q;
    slot_data_d  = slot_data_q;
    slot_wr_d    = slot_wr_q;
    slot_mask_d  = slot_mask_q;
    if (accept) begin
      slot_valid_d = 1'b1;
      slot_id_d    = alloc_id;
      slot_addr_d  = sel_addr & 32'hFFFF_FFF0;
      slot_data_d  = win ? c1_req_bits_data : c0_req_bits_data;
      slot_wr_d    = win ? c1_req_bits_isWr : c0_req_bits_isWr;
      slot_mask_d  = win ? c1_req_bits_mask : c0_req_bits_mask;
    end else if (mem_req_ready) begin
      slot_valid_d = 1'b0;
    end
  end

  // A freed ID and a newly allocated ID are always different bits of busy_q.
  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    if (resp_free) busy_d[mem_resp_bits_id] = 1'b0;
    if (accept) begin
      busy_d[alloc_id]  = 1'b1;
      owner_d[alloc_id] = win;
    end
    pref_d = (accept && RR) ? !win : pref_q;
    case ({accept, resp_free})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    err_d = err_q || (mem_resp_valid && !resp_known);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid_q <= 1'b0;
      slot_id_q    <= 4'd0;
      slot_addr_q  <= 32'd0;
      slot_data_q  <= 128'd0;
      slot_wr_q    <= 1'b0;
      slot_mask_q  <= 16'd0;
      busy_q       <= 16'd0;
      owner_q      <= 16'd0;
      pref_q       <= 1'b0;
      count_q      <= 5'd0;
      err_q        <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_id_q    <= slot_id_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      slot_wr_q    <= slot_wr_d;
      slot_mask_q  <= slot_mask_d;
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      pref_q       <= pref_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  assign mem_req_valid     = slot_valid_q;
  assign mem_req_bits_id   = slot_id_q;
  assign mem_req_bits_addr = slot_addr_q;
  assign mem_req_bits_data = slot_data_q;
  assign mem_req_bits_isWr = slot_wr_q;
  assign mem_req_bits_mask = slot_mask_q;
  assign outstanding       = count_q;
  assign err_unexpected_id = err_q;

endmodule

// File: tb/tb_dram_client_arbiter.sv
// Bench for dram_client_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_dram_client_arbiter;
  localparam int NUM_IDS = 8;
  localparam bit RR      = 1'b1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic         c0_req_valid = 0, c0_req_ready, c0_req_bits_isWr = 0;
  logic [31:0]  c0_req_bits_addr = 0;
  logic [127:0] c0_req_bits_data = 0, c0_resp_bits_data;
  logic [15:0]  c0_req_bits_mask = 0;
  logic         c0_resp_valid, c0_resp_ready = 0;
  logic         c1_req_valid = 0, c1_req_ready, c1_req_bits_isWr = 0;
  logic [31:0]  c1_req_bits_addr = 0;
  logic [127:0] c1_req_bits_data = 0, c1_resp_bits_data;
  logic [15:0]  c1_req_bits_mask = 0;
  logic         c1_resp_valid, c1_resp_ready = 0;
  logic         mem_req_valid, mem_req_ready = 0, mem_req_bits_isWr;
  logic [3:0]   mem_req_bits_id;
  logic [31:0]  mem_req_bits_addr;
  logic [127:0] mem_req_bits_data;
  logic [15:0]  mem_req_bits_mask;
  logic         mem_resp_valid = 0, mem_resp_ready;
  logic [3:0]   mem_resp_bits_id = 0;
  logic [127:0] mem_resp_bits_data = 0;
  logic [4:0]   outstanding;
  logic         err_unexpected_id;

  always #5 clock = ~clock;

  dram_client_arbiter #(.NUM_IDS(NUM_IDS), .RR(RR)) dut (
    .clock(clock), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready),
    .c0_req_bits_addr(c0_req_bits_addr), .c0_req_bits_data(c0_req_bits_data),
    .c0_req_bits_isWr(c0_req_bits_isWr), .c0_req_bits_mask(c0_req_bits_mask),
    .c0_resp_valid(c0_resp_valid), .c0_resp_ready(c0_resp_ready),
    .c0_resp_bits_data(c0_resp_bits_data),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready),
    .c1_req_bits_addr(c1_req_bits_addr), .c1_req_bits_data(c1_req_bits_data),
    .c1_req_bits_isWr(c1_req_bits_isWr), .c1_req_bits_mask(c1_req_bits_mask),
    .c1_resp_valid(c1_resp_valid), .c1_resp_ready(c1_resp_ready),
    .c1_resp_bits_data(c1_resp_bits_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_bits_id(mem_req_bits_id), .mem_req_bits_addr(mem_req_bits_addr),
    .mem_req_bits_data(mem_req_bits_data), .mem_req_bits_isWr(mem_req_bits_isWr),
    .mem_req_bits_mask(mem_req_bits_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_bits_id(mem_resp_bits_id), .mem_resp_bits_data(mem_resp_bits_data),
    .outstanding(outstanding), .err_unexpected_id(err_unexpected_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: ID table, owner table, one pending DRAM request.
  bit           m_busy[16];
  bit           m_owner[16];
  bit           m_pref;
  bit           m_full;
  logic [3:0]   m_id;
  logic [31:0]  m_addr;
  logic [127:0] m_data;
  logic         m_wr;
  logic [15:0]  m_mask;
  bit           m_err;
  logic [3:0]   exp_q[$];
  bit           last_resp_fire;

  always @(negedge clock) begin : compare
    int  n_busy, low, rid;
    bit  can, win, known, exp_mrr, v0, v1, acc, rfire;
    if (!reset) begin
      check("rst_c0_req_ready", c0_req_ready, 0);
      check("rst_c1_req_ready", c1_req_ready, 0);
      check("rst_mem_req_valid", mem_req_valid, 0);
      check("rst_c0_resp_valid", c0_resp_valid, 0);
      check("rst_c1_resp_valid", c1_resp_valid, 0);
      check("rst_outstanding", outstanding, 0);
      check("rst_err", err_unexpected_id, 0);
      for (int i = 0; i < 16; i++) begin m_busy[i] = 0; m_owner[i] = 0; end
      m_pref = 0; m_full = 0; m_err = 0; last_resp_fire = 0;
      exp_q.delete();
    end else begin
      n_busy = 0; low = -1;
      for (int i = 0; i < NUM_IDS; i++) begin
        if (m_busy[i]) n_busy++;
        else if (low < 0) low = i;
      end
      can = (!m_full || mem_req_ready) && (low >= 0);
      v0 = c0_req_valid; v1 = c1_req_valid;
      if (v0 && !v1)      win = 0;
      else if (v1 && !v0) win = 1;
      else                win = RR ? m_pref : 1'b1;
      if (v0 || v1) begin
        check("m_c0_req_ready", c0_req_ready, can && !win);
        check("m_c1_req_ready", c1_req_ready, can && win);
      end else begin
        check("m_ready_exclusive", c0_req_ready && c1_req_ready, 0);
        if (!can) check("m_ready_blocked", {c1_req_ready, c0_req_ready}, 0);
      end
      acc = (v0 || v1) && can;
      check("m_mem_req_valid", mem_req_valid, m_full);
      if (m_full) begin
        check("m_mem_req_id", mem_req_bits_id, m_id);
        check("m_mem_req_addr", mem_req_bits_addr, m_addr);
        check("m_mem_req_data", mem_req_bits_data, m_data);
        check("m_mem_req_isWr", mem_req_bits_isWr, m_wr);
        check("m_mem_req_mask", mem_req_bits_mask, m_mask);
      end
      rid = int'(mem_resp_bits_id);
      known = (rid < NUM_IDS) && m_busy[rid];
      exp_mrr = known ? (m_owner[rid] ? c1_resp_ready : c0_resp_ready) : 1'b1;
      check("m_mem_resp_ready", mem_resp_ready, exp_mrr);
      check("m_c0_resp_valid", c0_resp_valid, mem_resp_valid && known && !m_owner[rid]);
      check("m_c1_resp_valid", c1_resp_valid, mem_resp_valid && known && m_owner[rid]);
      if (mem_resp_valid && known)
        check("m_resp_data", m_owner[rid] ? c1_resp_bits_data : c0_resp_bits_data, mem_resp_bits_data);
      check("m_outstanding", outstanding, n_busy);
      check("m_err", err_unexpected_id, m_err);
      rfire = mem_resp_valid && exp_mrr;
      if (rfire) begin
        if (known) begin
          m_busy[rid] = 0;
          for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i] == mem_resp_bits_id) begin exp_q.delete(i); break; end
        end else m_err = 1;
      end
      last_resp_fire = rfire;
      if (m_full && mem_req_ready) begin
        exp_q.push_back(m_id);
        m_full = 0;
      end
      if (acc) begin
        m_full = 1;
        m_id   = 4'(low);
        m_addr = (win ? c1_req_bits_addr : c0_req_bits_addr) & 32'hFFFF_FFF0;
        m_data = win ? c1_req_bits_data : c0_req_bits_data;
        m_wr   = win ? c1_req_bits_isWr : c0_req_bits_isWr;
        m_mask = win ? c1_req_bits_mask : c0_req_bits_mask;
        m_busy[low]  = 1;
        m_owner[low] = win;
        if (RR) m_pref = !win;
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic at_neg();
    @(negedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 0; mem_resp_valid = 0; c0_req_valid = 0; c1_req_valid = 0;
    mem_req_ready = 0; c0_resp_ready = 0; c1_resp_ready = 0;
    tick(); tick();
    reset = 1;
  endtask

  task automatic random_cycle();
    c0_req_valid     = 1'($urandom_range(0, 1));
    c1_req_valid     = 1'($urandom_range(0, 1));
    c0_req_bits_addr = $urandom;
    c1_req_bits_addr = $urandom;
    c0_req_bits_data = {$urandom, $urandom, $urandom, $urandom};
    c1_req_bits_data = {$urandom, $urandom, $urandom, $urandom};
    c0_req_bits_isWr = 1'($urandom_range(0, 1));
    c1_req_bits_isWr = 1'($urandom_range(0, 1));
    c0_req_bits_mask = 16'($urandom);
    c1_req_bits_mask = 16'($urandom);
    c0_resp_ready    = ($urandom_range(0, 3) != 0);
    c1_resp_ready    = ($urandom_range(0, 3) != 0);
    mem_req_ready    = ($urandom_range(0, 3) != 0);
    if (!(mem_resp_valid && !last_resp_fire)) begin
      if (exp_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        mem_resp_valid     = 1;
        mem_resp_bits_id   = exp_q[$urandom_range(0, exp_q.size() - 1)];
        mem_resp_bits_data = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        mem_resp_valid = 0;
      end
    end
    tick();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    logic [1:0] exp2;
    // Reset held with c0 requesting, then release.
    c0_req_valid = 1; c0_req_bits_addr = 32'h1234_5678;
    at_neg();
    check("t1_ready_in_reset", c0_req_ready, 0);
    check("t1_mem_valid_in_reset", mem_req_valid, 0);
    tick(); reset = 1;
    at_neg();
    check("t1_c0_granted", c0_req_ready, 1);
    tick(); c0_req_valid = 0;
    at_neg();
    check("t1_mem_valid", mem_req_valid, 1);
    check("t1_mem_id", mem_req_bits_id, 0);
    check("t1_mem_addr", mem_req_bits_addr, 32'h1234_5670);
    tick();

    // Both clients requesting: alternating grants, consecutive IDs.
    do_reset();
    mem_req_ready = 1; c0_req_valid = 1; c1_req_valid = 1;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      exp2 = (k % 2 == 1) ? 2'b10 : 2'b01;
      check("t2_grant", {c1_req_ready, c0_req_ready}, exp2);
      if (k > 0) check("t2_id", mem_req_bits_id, k - 1);
      tick();
    end
    c0_req_valid = 0; c1_req_valid = 0;
    at_neg();
    check("t2_id_last", mem_req_bits_id, 3);
    tick();

    // Backpressure: held request stays stable, client stalls.
    do_reset();
    c1_req_valid = 1; c1_req_bits_addr = 32'hABCD_0129;
    at_neg();
    check("t3_first_ready", c1_req_ready, 1);
    tick(); c1_req_bits_addr = 32'h5555_5555;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      check("t3_held_valid", mem_req_valid, 1);
      check("t3_held_addr", mem_req_bits_addr, 32'hABCD_0120);
      check("t3_stalled", c1_req_ready, 0);
      tick();
    end
    mem_req_ready = 1;
    at_neg();
    check("t3_unstalled", c1_req_ready, 1);
    tick(); c1_req_valid = 0;

    // Fill every ID, then free ID 3 and see it reallocated.
    do_reset();
    mem_req_ready = 1; c0_req_valid = 1; c0_req_bits_isWr = 0;
    repeat (10) begin at_neg(); tick(); end
    at_neg();
    check("t4_full_outstanding", outstanding, 8);
    check("t4_full_c0_ready", c0_req_ready, 0);
    check("t4_full_c1_ready", c1_req_ready, 0);
    tick();
    mem_resp_valid = 1; mem_resp_bits_id = 3; c0_resp_ready = 1;
    at_neg();
    check("t4_resp_ready", mem_resp_ready, 1);
    check("t4_resp_c0", c0_resp_valid, 1);
    check("t4_no_same_cycle_reuse", c0_req_ready, 0);
    tick(); mem_resp_valid = 0;
    at_neg();
    check("t4_ready_again", c0_req_ready, 1);
    tick(); c0_req_valid = 0;
    at_neg();
    check("t4_realloc_id", mem_req_bits_id, 3);
    tick();

    // Routing: ID 0 owned by c1, c1 stalls the response first.
    do_reset();
    mem_req_ready = 1; c1_req_valid = 1;
    tick(); c1_req_valid = 0;
    tick();
    mem_resp_valid = 1; mem_resp_bits_id = 0; mem_resp_bits_data = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    c0_resp_ready = 1; c1_resp_ready = 0;
    at_neg();
    check("t5_stall_mem_ready", mem_resp_ready, 0);
    check("t5_no_c0_valid", c0_resp_valid, 0);
    check("t5_c1_valid", c1_resp_valid, 1);
    tick(); c1_resp_ready = 1;
    at_neg();
    check("t5_mem_ready", mem_resp_ready, 1);
    check("t5_c1_data", c1_resp_bits_data, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
    tick(); mem_resp_valid = 0;

    // Unknown ID: absorbed, flagged, sticky until reset.
    at_neg();
    check("t6_err_before", err_unexpected_id, 0);
    tick();
    mem_resp_valid = 1; mem_resp_bits_id = 9;
    at_neg();
    check("t6_mem_ready", mem_resp_ready, 1);
    check("t6_no_client_valid", {c1_resp_valid, c0_resp_valid}, 0);
    tick(); mem_resp_valid = 0;
    repeat (2) begin
      at_neg();
      check("t6_err_sticky", err_unexpected_id, 1);
      tick();
    end
    do_reset();
    at_neg();
    check("t6_err_cleared", err_unexpected_id, 0);
    tick();

    // Randomized traffic, with resets landing mid-transaction.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      repeat (800) random_cycle();
    end
    do_reset();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
